// File: rtl/pc_fetch_unit.sv
// Program counter and instruction fetch stage feeding the decoder.
// Optional FETCH_TIMEOUT_EN: fault after TIMEOUT_CYCLES fetch cycles without ack.
module pc_fetch_unit #(
   parameter logic [31:0] RESET_PC       = 32'h0000_0000,
   parameter int          TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [2:0]  i_pc_control,
   input  logic [25:0] i_jump_index,
   input  logic [31:0] i_jr_target,
   input  logic [15:0] i_branch_imm,
   input  logic        i_advance,
   output logic        o_imem_req,
   output logic [31:0] o_imem_addr,
   input  logic        i_imem_ack,
   input  logic [31:0] i_imem_rdata,
   output logic [31:0] o_instruction,
   output logic        o_instr_valid,
   output logic [31:0] o_pc,
   output logic [31:0] o_pc_plus4,
   output logic        o_fetch_fault,
   output logic [31:0] o_retired_count
);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD, S_FAULT} state_t;

   state_t      r_state;
   state_t      w_state_next;
   logic [31:0] r_pc;
   logic [31:0] r_instruction;
   logic        r_instr_valid;
   logic [31:0] r_retired_count;
   logic [31:0] w_pc_plus4;
   logic [31:0] w_branch_off;
   logic [31:0] w_next_pc;
   logic        w_illegal;
   logic        w_misaligned;
   logic        w_retire;
   logic        w_take_fault;
   logic        w_fetch_done;

   assign w_pc_plus4   = r_pc + 32'd4;
   assign w_branch_off = {{14{i_branch_imm[15]}}, i_branch_imm, 2'b00};

   always_comb begin
      w_next_pc = r_pc;
      w_illegal = 1'b0;
      case (i_pc_control)
         3'b000:        w_next_pc = w_pc_plus4;
         3'b001:        w_next_pc = {w_pc_plus4[31:28], i_jump_index, 2'b00};
         3'b010:        w_next_pc = i_jr_target;
         3'b011, 3'b100: w_next_pc = w_pc_plus4 + w_branch_off;
         default:       w_illegal = 1'b1;
      endcase
   end

   assign w_misaligned = (w_next_pc[1:0] != 2'b00);
   assign w_retire     = (r_state == S_HOLD) && i_advance;
   assign w_take_fault = w_illegal || w_misaligned;
   assign w_fetch_done = (r_state == S_FETCH) && i_imem_ack;

`ifdef FETCH_TIMEOUT_EN
   logic [31:0] r_wait_cnt;
   logic        w_timeout;

   // Counter sits at zero outside FETCH, so it is clear on every FETCH entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wait_cnt <= '0;
      end else if (r_state != S_FETCH) begin
         r_wait_cnt <= '0;
      end else if (!i_imem_ack) begin
         r_wait_cnt <= r_wait_cnt + 32'd1;
      end
   end

   assign w_timeout = (r_wait_cnt == 32'(TIMEOUT_CYCLES - 1));
`else
   logic w_timeout;
   assign w_timeout = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic; ack wins over a timeout on the same edge
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  w_state_next = S_FETCH;
         S_FETCH: begin
            if (i_imem_ack)     w_state_next = S_HOLD;
            else if (w_timeout) w_state_next = S_FAULT;
         end
         S_HOLD: begin
            if (i_advance) w_state_next = w_take_fault ? S_FAULT : S_FETCH;
         end
         default: w_state_next = S_FAULT;
      endcase
   end

   // State-decoded outputs
   always_comb begin
      o_imem_req    = 1'b0;
      o_fetch_fault = 1'b0;
      case (r_state)
         S_FETCH: o_imem_req    = 1'b1;
         S_FAULT: o_fetch_fault = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc            <= RESET_PC;
         r_instruction   <= '0;
         r_instr_valid   <= 1'b0;
         r_retired_count <= '0;
      end else begin
         if (w_fetch_done) begin
            r_instruction <= i_imem_rdata;
            r_instr_valid <= 1'b1;
         end
         // A faulting retirement still counts, but leaves the PC in place.
         if (w_retire) begin
            r_instr_valid   <= 1'b0;
            r_retired_count <= r_retired_count + 32'd1;
            if (!w_take_fault) r_pc <= w_next_pc;
         end
      end
   end

   assign o_imem_addr     = r_pc;
   assign o_pc            = r_pc;
   assign o_pc_plus4      = w_pc_plus4;
   assign o_instruction   = r_instruction;
   assign o_instr_valid   = r_instr_valid;
   assign o_retired_count = r_retired_count;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed self-checking bench for pc_fetch_unit (define FETCH_TIMEOUT_EN to add the timeout scenario).
module tb_pc_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [2:0]  i_pc_control = 3'b000;
   logic [25:0] i_jump_index = '0;
   logic [31:0] i_jr_target = '0;
   logic [15:0] i_branch_imm = '0;
   logic        i_advance = 1'b1;
   logic        o_imem_req;
   logic [31:0] o_imem_addr;
   logic        i_imem_ack = 1'b1;
   logic [31:0] i_imem_rdata = 32'h0000_0020;
   logic [31:0] o_instruction;
   logic        o_instr_valid;
   logic [31:0] o_pc;
   logic [31:0] o_pc_plus4;
   logic        o_fetch_fault;
   logic [31:0] o_retired_count;

   int n_cmp = 0;
   int n_err = 0;

   pc_fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_pc_control(i_pc_control), .i_jump_index(i_jump_index),
      .i_jr_target(i_jr_target), .i_branch_imm(i_branch_imm),
      .i_advance(i_advance),
      .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
      .i_imem_ack(i_imem_ack), .i_imem_rdata(i_imem_rdata),
      .o_instruction(o_instruction), .o_instr_valid(o_instr_valid),
      .o_pc(o_pc), .o_pc_plus4(o_pc_plus4), .o_fetch_fault(o_fetch_fault),
      .o_retired_count(o_retired_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Ends one cycle after release, i.e. in the first FETCH cycle.
   task automatic apply_reset();
      @(negedge clk) rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk) rst_n = 1'b1;
      tick();
   endtask

   // From FETCH with ack high: fetch, then retire with the given control.
   task automatic do_retire(input logic [2:0] ctrl, input logic [25:0] ji,
                            input logic [31:0] jr, input logic [15:0] bi);
      i_pc_control = ctrl; i_jump_index = ji; i_jr_target = jr; i_branch_imm = bi;
      tick();
      tick();
      i_pc_control = 3'b000;
      $display("retire ctrl=%b -> pc=%h count=%0d", ctrl, o_pc, o_retired_count);
   endtask

   task automatic test_reset();
      @(negedge clk);
      n_cmp++; if (o_imem_req !== 1'b0) begin n_err++; $display("FAIL reset_req got=%b exp=0", o_imem_req); end
      n_cmp++; if (o_pc !== 32'h0) begin n_err++; $display("FAIL reset_pc got=%h exp=0", o_pc); end
      n_cmp++; if (o_instruction !== 32'h0) begin n_err++; $display("FAIL reset_instr got=%h exp=0", o_instruction); end
      n_cmp++; if (o_instr_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", o_instr_valid); end
      n_cmp++; if (o_fetch_fault !== 1'b0) begin n_err++; $display("FAIL reset_fault got=%b exp=0", o_fetch_fault); end
      n_cmp++; if (o_retired_count !== 32'h0) begin n_err++; $display("FAIL reset_count got=%0d exp=0", o_retired_count); end
      apply_reset();
      $display("reset released: req=%b addr=%h", o_imem_req, o_imem_addr);
   endtask

   task automatic test_sequential();
      logic [31:0] exp_addr;
      for (int i = 0; i < 3; i++) begin
         exp_addr = 32'(i * 4);
         n_cmp++; if (o_imem_req !== 1'b1) begin n_err++; $display("FAIL seq_req got=%b exp=1", o_imem_req); end
         n_cmp++; if (o_imem_addr !== exp_addr) begin n_err++; $display("FAIL seq_addr got=%h exp=%h", o_imem_addr, exp_addr); end
         tick();
         n_cmp++; if (o_instruction !== 32'h0000_0020 || o_instr_valid !== 1'b1 || o_imem_req !== 1'b0) begin
            n_err++; $display("FAIL seq_hold instr=%h valid=%b req=%b exp 00000020/1/0", o_instruction, o_instr_valid, o_imem_req);
         end
         tick();
         $display("seq retire %0d: addr=%h", i, o_imem_addr);
      end
      n_cmp++; if (o_retired_count !== 32'd3) begin n_err++; $display("FAIL seq_count got=%0d exp=3", o_retired_count); end
      n_cmp++; if (o_imem_addr !== 32'd12) begin n_err++; $display("FAIL seq_addr3 got=%h exp=0000000c", o_imem_addr); end
   endtask

   task automatic test_jump();
      do_retire(3'b010, 26'h0, 32'h1000_0000, 16'h0);
      n_cmp++; if (o_pc !== 32'h1000_0000) begin n_err++; $display("FAIL jr_pc got=%h exp=10000000", o_pc); end
      n_cmp++; if (o_pc_plus4 !== 32'h1000_0004) begin n_err++; $display("FAIL pc_plus4 got=%h exp=10000004", o_pc_plus4); end
      do_retire(3'b001, 26'h000_0040, 32'h0, 16'h0);
      n_cmp++; if (o_imem_addr !== 32'h1000_0100 || o_imem_req !== 1'b1) begin
         n_err++; $display("FAIL jump_addr got=%h req=%b exp=10000100 req=1", o_imem_addr, o_imem_req);
      end
   endtask

   task automatic test_branch();
      do_retire(3'b010, 26'h0, 32'h0000_0100, 16'h0);
      do_retire(3'b011, 26'h0, 32'h0, 16'hFFFE);
      n_cmp++; if (o_pc !== 32'h0000_00FC) begin n_err++; $display("FAIL beq_pc got=%h exp=000000fc", o_pc); end
      do_retire(3'b010, 26'h0, 32'h0000_0100, 16'h0);
      do_retire(3'b000, 26'h0, 32'h0, 16'hFFFE);
      n_cmp++; if (o_pc !== 32'h0000_0104) begin n_err++; $display("FAIL seq_after_br got=%h exp=00000104", o_pc); end
      do_retire(3'b100, 26'h0, 32'h0, 16'h0003);
      n_cmp++; if (o_pc !== 32'h0000_0114) begin n_err++; $display("FAIL bne_pc got=%h exp=00000114", o_pc); end
   endtask

   task automatic test_fault();
      apply_reset();
      do_retire(3'b010, 26'h0, 32'h0000_0040, 16'h0);
      tick();
      i_pc_control = 3'b010; i_jr_target = 32'h0000_0202;
      tick();
      i_pc_control = 3'b000;
      repeat (3) tick();
      n_cmp++; if (o_fetch_fault !== 1'b1) begin n_err++; $display("FAIL misalign_fault got=%b exp=1", o_fetch_fault); end
      n_cmp++; if (o_pc !== 32'h0000_0040) begin n_err++; $display("FAIL misalign_pc got=%h exp=00000040", o_pc); end
      n_cmp++; if (o_imem_req !== 1'b0 || o_instr_valid !== 1'b0) begin
         n_err++; $display("FAIL misalign_req got req=%b valid=%b exp 0/0", o_imem_req, o_instr_valid);
      end
      n_cmp++; if (o_retired_count !== 32'd2) begin n_err++; $display("FAIL misalign_count got=%0d exp=2", o_retired_count); end
      $display("misaligned jr: fault=%b pc=%h", o_fetch_fault, o_pc);
      apply_reset();
      do_retire(3'b101, 26'h0, 32'h0, 16'h0);
      n_cmp++; if (o_fetch_fault !== 1'b1 || o_pc !== 32'h0) begin
         n_err++; $display("FAIL illegal_ctrl got fault=%b pc=%h exp fault=1 pc=0", o_fetch_fault, o_pc);
      end
      n_cmp++; if (o_retired_count !== 32'd1) begin n_err++; $display("FAIL illegal_count got=%0d exp=1", o_retired_count); end
      $display("illegal ctrl: fault=%b count=%0d", o_fetch_fault, o_retired_count);
   endtask

   task automatic test_delayed_ack();
      i_imem_ack = 1'b0;
      apply_reset();
      n_cmp++; if (o_fetch_fault !== 1'b0) begin n_err++; $display("FAIL reset_clears_fault got=%b exp=0", o_fetch_fault); end
      for (int i = 0; i < 5; i++) begin
         n_cmp++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h0) begin
            n_err++; $display("FAIL wait_req cycle %0d got req=%b addr=%h exp 1/0", i, o_imem_req, o_imem_addr);
         end
         if (i == 4) begin i_imem_ack = 1'b1; i_imem_rdata = 32'hABCD_1234; end
         tick();
      end
      i_imem_ack = 1'b0;
      n_cmp++; if (o_instruction !== 32'hABCD_1234 || o_instr_valid !== 1'b1) begin
         n_err++; $display("FAIL late_fetch got=%h valid=%b exp=abcd1234/1", o_instruction, o_instr_valid);
      end
      n_cmp++; if (o_retired_count !== 32'd0) begin n_err++; $display("FAIL advance_in_fetch got=%0d exp=0", o_retired_count); end
      tick();
      tick();
      n_cmp++; if (o_retired_count !== 32'd1 || o_imem_addr !== 32'd4 || o_imem_req !== 1'b1) begin
         n_err++; $display("FAIL refetch got count=%0d addr=%h req=%b exp 1/4/1", o_retired_count, o_imem_addr, o_imem_req);
      end
      rst_n = 1'b0;
      #1;
      n_cmp++; if (o_imem_req !== 1'b0 || o_pc !== 32'h0) begin
         n_err++; $display("FAIL async_reset got req=%b pc=%h exp 0/0", o_imem_req, o_pc);
      end
      i_imem_ack = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++; if (o_instr_valid !== 1'b0 || o_instruction !== 32'h0) begin
         n_err++; $display("FAIL ack_in_reset got valid=%b instr=%h exp 0/0", o_instr_valid, o_instruction);
      end
      $display("mid-fetch reset: req=%b pc=%h", o_imem_req, o_pc);
      i_imem_rdata = 32'h0000_0020;
      apply_reset();
   endtask

`ifdef FETCH_TIMEOUT_EN
   task automatic test_timeout();
      i_imem_ack = 1'b0;
      apply_reset();
      for (int i = 0; i < 4; i++) begin
         n_cmp++; if (o_fetch_fault !== 1'b0) begin n_err++; $display("FAIL timeout_early cycle %0d got=%b exp=0", i, o_fetch_fault); end
         tick();
      end
      n_cmp++; if (o_fetch_fault !== 1'b1 || o_imem_req !== 1'b0) begin
         n_err++; $display("FAIL timeout_fault got fault=%b req=%b exp 1/0", o_fetch_fault, o_imem_req);
      end
      apply_reset();
      repeat (3) tick();
      i_imem_ack = 1'b1;
      tick();
      n_cmp++; if (o_fetch_fault !== 1'b0 || o_instr_valid !== 1'b1) begin
         n_err++; $display("FAIL timeout_ack_wins got fault=%b valid=%b exp 0/1", o_fetch_fault, o_instr_valid);
      end
      $display("timeout: ack on limit edge -> valid=%b fault=%b", o_instr_valid, o_fetch_fault);
   endtask
`endif

   initial begin
      test_reset();
      test_sequential();
      test_jump();
      test_branch();
      test_fault();
      test_delayed_ack();
`ifdef FETCH_TIMEOUT_EN
      test_timeout();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter and instruction-fetch stage directly upstream of the instruction decoder.
- Holds the 32-bit PC and fetches the word at PC from instruction memory over a req/ack handshake.
- Presents the latched instruction word to the decoder.
- Consumes the decoder's 3-bit pc_control, plus jump, register and immediate operands, to compute the next PC when the current instruction retires.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TIMEOUT_CYCLES, 16, max cycles in FETCH without ack before fault (only with FETCH_TIMEOUT_EN).

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- pc_control  in  3  next-PC select from decoder: 000 seq, 001 j/jal, 010 jr, 011 beq taken, 100 bne taken.
- jump_index  in  26  instruction[25:0] for j/jal.
- jr_target  in  32  rs register value for jr.
- branch_imm  in  16  instruction[15:0] for beq/bne.
- advance  in  1  current instruction retires this cycle; sampled only in HOLD.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address (equals pc).
- imem_ack  in  1  fetch data valid this cycle.
- imem_rdata  in  32  fetched instruction word.
- instruction  out  32  latched instruction to decoder.
- instr_valid  out  1  instruction holds a valid fetched word.
- pc  out  32  address of current instruction.
- pc_plus4  out  32  pc + 4, combinational (jal link value).
- fetch_fault  out  1  sticky fault: illegal pc_control, misaligned target, or timeout.
- retired_count  out  32  count of retired instructions, wraps modulo 2^32.

Behaviour:
- Async reset values: pc = RESET_PC, instruction = 0, instr_valid = 0, imem_req = 0, fetch_fault = 0, retired_count = 0, state = IDLE. Reset asserted mid-fetch drops imem_req immediately; a late ack is ignored.
- States:
  - IDLE: goes to FETCH on the first edge after rst_n deasserts.
  - FETCH: imem_req = 1, imem_addr = pc. On an edge with imem_ack = 1: instruction <= imem_rdata, instr_valid <= 1, go to HOLD. Zero-wait memory (ack in the same cycle) is legal.
  - HOLD: imem_req = 0; instruction is stable. On an edge with advance = 1: pc <= next_pc, instr_valid <= 0, retired_count += 1, go to FETCH.
  - FAULT: imem_req = 0, instr_valid = 0, fetch_fault = 1. Exits only via reset.
- imem_ack outside FETCH is ignored. advance outside HOLD is ignored.
- Throughput: minimum 2 cycles per instruction with zero-wait memory.
- next_pc by pc_control (all arithmetic mod 2^32):
  - 000: pc_plus4.
  - 001: {pc_plus4[31:28], jump_index, 2'b00}.
  - 010: jr_target.
  - 011/100: pc_plus4 + (sign-extended branch_imm << 2). Branch-taken qualification is done upstream.
  - 101-111: illegal → FAULT; pc unchanged, retired_count still increments.
- Misaligned target: if next_pc[1:0] != 0 (jr only can produce this) → FAULT; pc unchanged.
- pc_control and the operands are sampled only on the retiring edge; changes at other times have no effect.

Optional Feature:
- FETCH_TIMEOUT_EN defined: 
  - A wait counter clears on FETCH entry and increments every FETCH cycle without ack.
  - When it reaches TIMEOUT_CYCLES without ack → FAULT.
  - Ack on the same edge the count hits the limit wins (normal fetch).
- Not defined: no counter; FETCH waits indefinitely.

Test Plan:
- Reset release with RESET_PC = 0, zero-wait memory returning 32'h0000_0020, advance = 1 with pc_control = 000 each HOLD → imem_addr sequence 0, 4, 8; instruction = 32'h0000_0020 in HOLD; retired_count = 3 after three retirements.
- pc = 32'h1000_0000, pc_control = 001, jump_index = 26'h000_0040 → next imem_addr = 32'h1000_0100.
- pc = 32'h0000_0100, pc_control = 011, branch_imm = 16'hFFFE → next pc = 32'h0000_00FC. Same stimulus with pc_control = 000 → 32'h0000_0104.
- pc_control = 010, jr_target = 32'h0000_0202 → fetch_fault = 1, pc unchanged, imem_req stays 0. pc_control = 101 → fault as well.
- Ack delayed 5 cycles → imem_req held 5 cycles, addr stable; rst_n pulsed low mid-FETCH → imem_req = 0 immediately, pc = RESET_PC.
- FETCH_TIMEOUT_EN with TIMEOUT_CYCLES = 4, ack never asserted → fetch_fault rises after 4 FETCH cycles. Ack on the 4th cycle → normal HOLD, no fault.
